fifo_uart_tx: RTL and testbench

Serial transmit stage that drains the synchronous FIFO (`sync_fifo_cnt`) and sends each byte on a single line as an 8N1-style UART frame. It sits directly downstream of the FIFO and uses the FIFO's read side: `empty`, `rd_en` and registered `data_out` with one-cycle read latency. A producer fills the FIFO at its own pace, and this block paces the bytes out at a fixed bit period.

---
 rtl/fifo_uart_tx.sv | 180 ++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : UART-style (8N1) serial transmitter that drains a synchronous
//            FIFO with one-cycle read latency. Each byte is popped, latched
//            and shifted out LSB first between one start bit (0) and one
//            stop bit (1). Each serial bit lasts CLKS_PER_BIT clock cycles.
//
// Parameters:
//   DATA_WIDTH   - payload bits per frame (must match the FIFO width)
//   CLKS_PER_BIT - clock cycles per serial bit (>= 2)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   tx_en      in   permits a new pop from IDLE; a running frame completes
//   fifo_empty in   FIFO empty flag
//   fifo_data  in   FIFO registered read data
//   fifo_rd_en out  single-cycle FIFO pop strobe
//   tx         out  registered serial line, idle high
//   busy       out  high in every state except IDLE
//   frame_done out  one-cycle pulse in the last stop-bit cycle
//
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W  = $clog2(DATA_WIDTH) + 1;

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_FETCH = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [DATA_WIDTH-1:0]   r_shift;
    logic [DATA_WIDTH-1:0]   w_shift_next;
    logic [c_BAUD_W-1:0]     r_baud;
    logic [c_BAUD_W-1:0]     w_baud_next;
    logic [c_BIT_W-1:0]      r_bit;
    logic [c_BIT_W-1:0]      w_bit_next;
    logic                    r_tx;
    logic                    w_tx_next;
    logic                    w_baud_wrap;

    assign w_baud_wrap = (r_baud == c_BAUD_LAST);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_tx    <= w_tx_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;

        case (r_state)
            ST_IDLE: begin
                // tx_en and fifo_empty are only looked at here, so a frame
                // in flight is never affected by either of them.
                if (tx_en && !fifo_empty) begin
                    w_state_next = ST_POP;
                end
            end

            ST_POP: begin
                w_state_next = ST_FETCH;
            end

            ST_FETCH: begin
                // The FIFO output register was updated by the pop strobe of
                // the previous cycle, so the data is valid now.
                w_shift_next = fifo_data;
                w_bit_next   = '0;
                w_baud_next  = '0;
                w_state_next = ST_START;
            end

            ST_START: begin
                if (w_baud_wrap) begin
                    w_baud_next  = '0;
                    w_state_next = ST_DATA;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end

            ST_DATA: begin
                if (w_baud_wrap) begin
                    w_baud_next  = '0;
                    w_shift_next = r_shift >> 1;
                    w_bit_next   = r_bit + 1'b1;
                    if (r_bit == c_BIT_LAST) begin
                        w_state_next = ST_STOP;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end

            ST_STOP: begin
                if (w_baud_wrap) begin
                    w_baud_next  = '0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Serial line: derived from the next state so that the registered
    // output lines up exactly with the state it belongs to.
    // ------------------------------------------------------------------
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_shift_next[0];
            default:  w_tx_next = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from the state register
    // ------------------------------------------------------------------
    assign tx         = r_tx;
    assign fifo_rd_en = (r_state == ST_POP);
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = (r_state == ST_STOP) && w_baud_wrap;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Self-checking bench for fifo_uart_tx (DATA_WIDTH=8,
//            CLKS_PER_BIT=4) with a 16-deep behavioural FIFO on its read side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int c_DW    = 8;
    localparam int c_CPB   = 4;
    localparam int c_DEPTH = 16;
    localparam int c_FRAME = (c_DW + 2) * c_CPB;   // 40

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            fifo_rst = 1'b1;
    logic            tx_en = 1'b0;
    logic            fifo_empty;
    logic [c_DW-1:0] fifo_data;
    logic            fifo_rd_en;
    logic            tx;
    logic            busy;
    logic            frame_done;

    logic            wr_en = 1'b0;
    logic [c_DW-1:0] wr_data = '0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DATA_WIDTH   (c_DW),
        .CLKS_PER_BIT (c_CPB)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Behavioural synchronous FIFO: registered data_out, one-cycle latency.
    logic [c_DW-1:0] mem [c_DEPTH];
    logic [3:0]      wr_ptr;
    logic [3:0]      rd_ptr;
    int              count;
    int              overflow;

    assign fifo_empty = (count == 0);

    always @(posedge clk or posedge fifo_rst) begin
        if (fifo_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= 0;
            fifo_data <= '0;
            overflow  <= 0;
        end else begin
            if (wr_en && count == c_DEPTH) overflow <= overflow + 1;
            if (wr_en && count < c_DEPTH) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 4'd1;
            end
            if (fifo_rd_en && count > 0) begin
                fifo_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 4'd1;
            end
            count <= count + ((wr_en && count < c_DEPTH) ? 1 : 0)
                           - ((fifo_rd_en && count > 0) ? 1 : 0);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Protocol monitors, sampled away from the active edge.
    int pops = 0;
    int bad_pops = 0;
    int dbl_pops = 0;
    int fd_pulses = 0;
    logic prev_rd = 1'b0;

    always @(negedge clk) begin
        if (fifo_rd_en) pops = pops + 1;
        if (fifo_rd_en && fifo_empty) bad_pops = bad_pops + 1;
        if (fifo_rd_en && prev_rd) dbl_pops = dbl_pops + 1;
        if (frame_done) fd_pulses = fd_pulses + 1;
        prev_rd = fifo_rd_en;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [c_DW-1:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Waits for the start bit; t is the cycle number of the first tx=0 sample.
    task automatic wait_start(input string tag, input int budget, output int t);
        bit found = 0;
        t = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (tx == 1'b0) begin
                found = 1;
                t = cyc;
            end
        end
        if (!found) check({tag, "_start_timeout"}, 64'd1, 64'd0);
    endtask

    // Captures one frame starting at the current (start-bit) sample.
    task automatic capture_frame(input logic [c_DW-1:0] b, input string tag, input int drop_at);
        logic [c_FRAME-1:0] obs_tx;
        logic [c_FRAME-1:0] obs_fd;
        logic [c_FRAME-1:0] exp_tx;
        logic [c_FRAME-1:0] exp_fd;
        exp_fd = '0;
        exp_fd[c_FRAME-1] = 1'b1;
        for (int k = 0; k < c_FRAME; k++) begin
            if (k > 0) @(negedge clk);
            obs_tx[k] = tx;
            obs_fd[k] = frame_done;
            if (k < c_CPB)                exp_tx[k] = 1'b0;
            else if (k < (c_DW + 1) * c_CPB) exp_tx[k] = b[(k - c_CPB) / c_CPB];
            else                          exp_tx[k] = 1'b1;
            if (k == drop_at) tx_en = 1'b0;
        end
        check({tag, "_tx"}, 64'(obs_tx), 64'(exp_tx));
        check({tag, "_frame_done"}, 64'(obs_fd), 64'(exp_fd));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, tprev, c0, p0, f0;
        logic [c_DW-1:0] b6 [8];

        // ---------------- 1: reset state ----------------
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        fifo_rst = 1'b0;
        tx_en    = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_pops", 64'(pops), 64'd0);

        // ---------------- 2: single byte 0xA5 ----------------
        p0 = pops;
        f0 = fd_pulses;
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        c0 = cyc;
        check("a5_empty_fell", 64'(fifo_empty), 64'd0);
        wait_start("a5", 20, t0);
        check("a5_latency", 64'(t0 - c0), 64'd3);
        capture_frame(8'hA5, "a5", -1);
        @(negedge clk);
        check("a5_busy_fall", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        check("a5_pops", 64'(pops - p0), 64'd1);
        check("a5_fd_pulses", 64'(fd_pulses - f0), 64'd1);
        check("a5_count", 64'(count), 64'd0);

        // ---------------- 3: burst drain of 16 bytes ----------------
        tx_en = 1'b0;
        p0 = pops;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        check("burst_full_count", 64'(count), 64'd16);
        tx_en = 1'b1;
        tprev = -1;
        for (int i = 0; i < 16; i++) begin
            wait_start("burst", 60, t1);
            if (tprev >= 0) check($sformatf("burst_pitch%0d", i), 64'(t1 - tprev), 64'd43);
            tprev = t1;
            capture_frame(8'(i), $sformatf("burst%0d", i), -1);
            check($sformatf("burst_count%0d", i), 64'(count), 64'(15 - i));
        end
        @(negedge clk);
        check("burst_busy_fall", 64'(busy), 64'd0);
        repeat (10) @(negedge clk);
        check("burst_pops", 64'(pops - p0), 64'd16);

        // ---------------- 4: tx_en gating ----------------
        p0 = pops;
        push(8'h3C);
        push(8'hC3);
        wait_start("g3c", 20, t0);
        capture_frame(8'h3C, "g3c", 20);
        repeat (20) @(negedge clk);
        check("gate_one_pop", 64'(pops - p0), 64'd1);
        check("gate_idle_tx", 64'(tx), 64'd1);
        check("gate_idle_busy", 64'(busy), 64'd0);
        check("gate_count", 64'(count), 64'd1);
        tx_en = 1'b1;
        c0 = cyc;
        wait_start("gc3", 20, t0);
        check("gate_latency", 64'(t0 - c0), 64'd3);
        capture_frame(8'hC3, "gc3", -1);

        // ---------------- 5: reset mid-frame ----------------
        repeat (5) @(negedge clk);
        push(8'h5A);
        push(8'h77);
        wait_start("r5a", 20, t0);
        f0 = fd_pulses;
        repeat (12) @(negedge clk);
        check("r5a_in_data", 64'(busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("r5a_tx_async", 64'(tx), 64'd1);
        check("r5a_busy_async", 64'(busy), 64'd0);
        check("r5a_fd_async", 64'(frame_done), 64'd0);
        check("r5a_rd_async", 64'(fifo_rd_en), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_start("r77", 20, t0);
        check("r5a_no_frame_done", 64'(fd_pulses - f0), 64'd0);
        capture_frame(8'h77, "r77", -1);
        check("r77_count", 64'(count), 64'd0);

        // ---------------- 6: concurrent producer ----------------
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) b6[i] = 8'(i * 37 + 11);
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    wr_en   = 1'b1;
                    wr_data = b6[i];
                    @(negedge clk);
                    wr_en = 1'b0;
                    repeat (18) @(negedge clk);
                end
            end
            begin
                for (int j = 0; j < 8; j++) begin
                    wait_start("conc", 80, t0);
                    capture_frame(b6[j], $sformatf("conc%0d", j), -1);
                end
            end
        join
        repeat (5) @(negedge clk);
        check("conc_count", 64'(count), 64'd0);
        check("no_overflow", 64'(overflow), 64'd0);
        check("no_pop_when_empty", 64'(bad_pops), 64'd0);
        check("no_back_to_back_pop", 64'(dbl_pops), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
